// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable integer clock divider with a load/ack handshake for glitch-free divisor reload.
// Optional feature macro CLK_DIV_PHASE_EN adds a phase_ofs input that sets the counter start value.
module clk_div_gen #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
`ifdef CLK_DIV_PHASE_EN
  input  logic [WIDTH-1:0] phase_ofs,
`endif
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             busy,
  output logic             clk_out,
  output logic             period_tick
);

  localparam logic [WIDTH-1:0] RST_DIV = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

  typedef enum logic {RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             ack_d, busy_d, clk_d, tick_d;
  logic [WIDTH-1:0] cnt_eff, start_sw, half, req_div;
  logic             tc;

`ifdef CLK_DIV_PHASE_EN
  // The first edge after reset behaves as if the counter already sat at the start value.
  logic             first_q;
  logic [WIDTH-1:0] start_rst;

  assign start_sw  = (phase_ofs >= pend_q) ? pend_q - WIDTH'(1) : phase_ofs;
  assign start_rst = (phase_ofs >= act_q) ? act_q - WIDTH'(1) : phase_ofs;
  assign cnt_eff   = first_q ? start_rst : cnt_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) first_q <= 1'b1;
    else     first_q <= 1'b0;
  end
`else
  assign start_sw = '0;
  assign cnt_eff  = cnt_q;
`endif

  // H = ceil(N/2) without leaving WIDTH bits; divisors below 2 are promoted to 2.
  assign half    = (act_q >> 1) + WIDTH'(act_q[0]);
  assign tc      = (cnt_eff == act_q - WIDTH'(1));
  assign req_div = (div_val < WIDTH'(2)) ? WIDTH'(2) : div_val;

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    busy_d  = busy;
    ack_d   = 1'b0;
    cnt_d   = tc ? '0 : cnt_eff + WIDTH'(1);
    clk_d   = (cnt_eff < half);
    tick_d  = tc;
    case (state_q)
      RUN: begin
        if (div_load) begin
          pend_d  = req_div;
          busy_d  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        // Switch only at a period boundary so no output period is ever truncated.
        if (tc) begin
          act_d   = pend_q;
          cnt_d   = start_sw;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      act_q       <= RST_DIV;
      pend_q      <= RST_DIV;
      div_ack     <= 1'b0;
      busy        <= 1'b0;
      clk_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      div_ack     <= ack_d;
      busy        <= busy_d;
      clk_out     <= clk_d;
      period_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: scoreboard bench for clk_div_gen; a period-level reference model queues the
// expected outputs of every clock edge and a separate monitor pops and compares them.
module tb_clk_div_gen;

  localparam int DEF_N = 2;

  typedef struct packed {
    logic clk;
    logic tick;
    logic ack;
    logic busy;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_ack, busy, clk_out, period_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t exp_q[$];

  // Reference model: active divisor, position inside the current output period, pending request.
  int m_n      = DEF_N;
  int m_pos    = 0;
  int m_pend_n = 0;
  bit m_pend   = 1'b0;

  clk_div_gen #(.WIDTH(8), .DEFAULT_DIV(DEF_N)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .div_val     (div_val),
    .div_load    (div_load),
    .div_ack     (div_ack),
    .busy        (busy),
    .clk_out     (clk_out),
    .period_tick (period_tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // The high phase covers positions whose doubled index is below N, i.e. ceil(N/2) positions.
  task automatic model_push(input bit load, input int val);
    exp_t e;
    bit   last;
    bit   was_pend;
    was_pend = m_pend;
    last     = (m_pos == m_n - 1);
    e.clk    = (2 * m_pos < m_n);
    e.tick   = last;
    e.ack    = was_pend && last;
    if (e.ack) begin
      m_n    = m_pend_n;
      m_pend = 1'b0;
      m_pos  = 0;
    end else begin
      m_pos = last ? 0 : m_pos + 1;
    end
    if (load && !was_pend) begin
      m_pend_n = (val < 2) ? 2 : val;
      m_pend   = 1'b1;
    end
    e.busy = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit load, input logic [7:0] val);
    div_load = load;
    div_val  = val;
    model_push(load, int'(val));
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  task automatic idle_until_ready();
    int guard = 0;
    while (m_pend && guard < 600) begin
      step(1'b0, 8'($urandom));
      guard++;
    end
    if (m_pend) begin
      checks++;
      errors++;
      $display("FAIL wait_ack cycle %0d: still pending after %0d cycles, required 0", cyc, guard);
    end
  endtask

  task automatic wait_terminal();
    int guard = 0;
    while (m_pos != m_n - 1 && guard < 600) begin
      step(1'b0, 8'($urandom));
      guard++;
    end
  endtask

  task automatic reset_pulse();
    div_load = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_div_ack", div_ack, 1'b0);
    chk("rst_period_tick", period_tick, 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst    = 1'b0;
    m_n    = DEF_N;
    m_pos  = 0;
    m_pend = 1'b0;
  endtask

  // Monitor: every clock edge outside reset presents one output sample to compare.
  initial begin
    forever begin
      @(posedge clk_in);
      cyc++;
      if (!rst) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard cycle %0d: output seen with no expected entry", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("clk_out", clk_out, e.clk);
          chk("period_tick", period_tick, e.tick);
          chk("div_ack", div_ack, e.ack);
          chk("busy", busy, e.busy);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    #1 rst = 1'b1;
    #1;
    chk("init_clk_out", clk_out, 1'b0);
    chk("init_busy", busy, 1'b0);
    chk("init_div_ack", div_ack, 1'b0);
    chk("init_period_tick", period_tick, 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;

    idle(10);
    step(1'b1, 8'd5);
    idle(20);
    step(1'b1, 8'd8);
    idle(1);
    step(1'b1, 8'd3);
    idle(30);
    step(1'b1, 8'd6);
    idle_until_ready();
    wait_terminal();
    step(1'b1, 8'd4);
    idle(20);
    step(1'b1, 8'd0);
    idle(10);
    step(1'b1, 8'd1);
    idle(10);
    step(1'b1, 8'd2);
    idle(10);
    step(1'b1, 8'd255);
    idle(300);
    step(1'b1, 8'd9);
    idle(3);
    reset_pulse();
    idle(10);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse();
      end else if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 15) == 0) step(1'b1, 8'($urandom_range(200, 255)));
        else                            step(1'b1, 8'($urandom_range(0, 12)));
      end else begin
        step(1'b0, 8'($urandom));
      end
    end
    idle(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
